// File: rtl/scr1_wb_pkg.sv
// Shared types for the SCR1 data-memory to Wishbone request-port adapter:
// SCR1 memory encodings, adapter FSM states and the byte-strobe helper.
package scr1_wb_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } dmem_wb_state_e;

    // Byte-lane enables for an access of the given width at the given byte offset.
    function automatic logic [3:0] strb_gen(input logic [1:0] width,
                                            input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  strb = 4'b0001 << addr_lo;
            SCR1_MEM_WIDTH_HWORD: strb = 4'b0011 << addr_lo;
            SCR1_MEM_WIDTH_WORD:  strb = 4'b1111;
            default:              strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/scr1_dmem_wb_adapter_if.sv
// Bus bundles around the adapter: the SCR1 core data-memory port and the
// simple request port of the Wishbone master.
interface scr1_dmem_if;
    logic        dmem_req;
    logic        dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_req_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;

    // Core side issues requests
    modport master (
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_req_ack, dmem_rdata, dmem_resp
    );

    // Adapter side serves them
    modport slave (
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_req_ack, dmem_rdata, dmem_resp
    );
endinterface

interface scr1_wb_mem_if;
    logic        mem_valid;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_ack;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    // Adapter side presents requests to the Wishbone master
    modport master (
        output mem_valid, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  mem_ack, mem_ready, mem_rdata
    );

    // Wishbone master side accepts and completes them
    modport slave (
        input  mem_valid, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output mem_ack, mem_ready, mem_rdata
    );
endinterface

// File: rtl/scr1_dmem_lane_align.sv
// Combinational lane logic: byte strobes, write-data replication across
// lanes and the misalignment flag for an incoming SCR1 request.
module scr1_dmem_lane_align
    import scr1_wb_pkg::*;
(
    input  logic [1:0]  i_width,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_strb,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    always_comb begin
        o_strb       = strb_gen(i_width, i_addr_lo);
        o_wdata      = i_wdata;
        o_misaligned = 1'b0;
        // Replicating the narrow datum puts it on every lane, so the strobes alone pick the target bytes
        case (i_width)
            SCR1_MEM_WIDTH_BYTE: begin
                o_wdata = {4{i_wdata[7:0]}};
            end
            SCR1_MEM_WIDTH_HWORD: begin
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            SCR1_MEM_WIDTH_WORD: begin
                o_misaligned = |i_addr_lo;
            end
            default: begin
                o_misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/scr1_dmem_wb_adapter.sv
// SCR1 data-memory port to Wishbone master request-port adapter: one
// transaction at a time, alignment check, completion timeout with drain.
module scr1_dmem_wb_adapter
    import scr1_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
)
(
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    scr1_dmem_if.slave    dmem,
    scr1_wb_mem_if.master mem
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES);

    dmem_wb_state_e      r_state;
    dmem_wb_state_e      w_state_nxt;
    type_scr1_mem_resp_e r_resp;
    type_scr1_mem_resp_e w_resp_nxt;

    logic [3:0]       w_strb;
    logic [31:0]      w_wdata_rep;
    logic             w_misaligned;
    logic             w_timeout;
    logic             w_issue;
    logic             w_reject;
    logic             w_capture;
    logic             w_set_drain;

    logic             r_cmd_wr;
    logic             r_drain;
    logic             r_mem_valid;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_wstrb;
    logic [31:0]      r_rdata;
    logic [CNT_W-1:0] r_cnt;

    scr1_dmem_lane_align u_lane_align (
        .i_width      (dmem.dmem_width),
        .i_addr_lo    (dmem.dmem_addr[1:0]),
        .i_wdata      (dmem.dmem_wdata),
        .o_strb       (w_strb),
        .o_wdata      (w_wdata_rep),
        .o_misaligned (w_misaligned)
    );

    // A zero limit disables the timeout entirely
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == ST_WAIT) && (r_cnt == TMO_LIM);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_resp_nxt  = SCR1_MEM_RESP_NOTRDY;
        w_issue     = 1'b0;
        w_reject    = 1'b0;
        w_capture   = 1'b0;
        w_set_drain = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dmem.dmem_req) begin
                    if (w_misaligned) begin
                        w_reject    = 1'b1;
                        w_resp_nxt  = SCR1_MEM_RESP_RDY_ER;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem.mem_ack) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem.mem_ready) begin
                    w_capture   = 1'b1;
                    w_resp_nxt  = SCR1_MEM_RESP_RDY_OK;
                    w_state_nxt = ST_RESP;
                end else if (w_timeout) begin
                    w_set_drain = 1'b1;
                    w_resp_nxt  = SCR1_MEM_RESP_RDY_ER;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = r_drain ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                // The master still owes a completion for the abandoned request
                if (mem.mem_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cmd_wr    <= 1'b0;
            r_drain     <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_rdata     <= '0;
            r_resp      <= SCR1_MEM_RESP_NOTRDY;
            r_cnt       <= '0;
        end else begin
            r_mem_valid <= (w_state_nxt == ST_REQ);
            r_resp      <= w_resp_nxt;
            r_cnt       <= (r_state == ST_WAIT) ? r_cnt + 1'b1 : '0;

            if (w_issue) begin
                r_cmd_wr    <= dmem.dmem_cmd;
                r_mem_addr  <= {dmem.dmem_addr[31:2], 2'b00};
                r_mem_wstrb <= dmem.dmem_cmd ? w_strb : 4'b0000;
                r_mem_wdata <= w_wdata_rep;
            end

            if (w_reject || w_set_drain) begin
                r_rdata <= '0;
            end else if (w_capture) begin
                r_rdata <= r_cmd_wr ? '0 : mem.mem_rdata;
            end

            if (w_set_drain) begin
                r_drain <= 1'b1;
            end else if (r_state == ST_RESP) begin
                r_drain <= 1'b0;
            end
        end
    end

    assign dmem.dmem_req_ack = (r_state == ST_IDLE);
    assign dmem.dmem_rdata   = r_rdata;
    assign dmem.dmem_resp    = r_resp;

    assign mem.mem_valid   = r_mem_valid;
    assign mem.mem_addr_o  = r_mem_addr;
    assign mem.mem_wdata_o = r_mem_wdata;
    assign mem.mem_wstrb_o = r_mem_wstrb;

endmodule
